// File: rtl/activation_controller_pkg.sv
// rtl/activation_controller_pkg.sv - shared types and constants for the activation controller
// Package act_pkg: activation function and FSM state enums, row type, output buffer depth.
package act_pkg;

    localparam int ACT_DATA_WIDTH = 11;
    localparam int ACT_SA_LENGTH  = 256;
    localparam int ACT_ROW_W      = 16;
    localparam int OUT_DEPTH      = 2;

    typedef enum logic [1:0] {
        RELU    = 2'd0,
        SIGMOID = 2'd1,
        TANH    = 2'd2,
        BYPASS  = 2'd3
    } act_func_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } act_state_e;

    // One accumulator row at the default geometry, lane 0 first.
    typedef logic signed [ACT_DATA_WIDTH-1:0] row_t [ACT_SA_LENGTH];

endpackage

// File: rtl/activation_controller_if.sv
// rtl/activation_controller_if.sv - handshake/bus bundle between the activation controller and its neighbours
// Groups: layer config (cfg_*), accumulator row input (in_*), activation unit link (act_*),
// result row output (out_*), status (busy, done). Optional stall counters under ACT_CTRL_PERF_EN.
// Modports: slave = controller side, master = surrounding datapath/environment side.
// Rows are packed [lane][bit]; each lane is a signed fixed-point value the controller never interprets.
interface activation_controller_if #(
    parameter int DATA_WIDTH = act_pkg::ACT_DATA_WIDTH,
    parameter int SA_LENGTH  = act_pkg::ACT_SA_LENGTH,
    parameter int ROW_W      = act_pkg::ACT_ROW_W
);
    logic                                  cfg_valid;
    logic                                  cfg_ready;
    logic [1:0]                            cfg_func;
    logic [ROW_W-1:0]                      cfg_rows;

    logic                                  in_valid;
    logic                                  in_ready;
    logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  in_data;

    logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  act_in;
    logic [1:0]                            act_sel;
    logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  act_out;

    logic                                  out_valid;
    logic                                  out_ready;
    logic [SA_LENGTH-1:0][DATA_WIDTH-1:0]  out_data;
    logic                                  out_last;

    logic                                  busy;
    logic                                  done;
`ifdef ACT_CTRL_PERF_EN
    logic [31:0]                           stall_in_cnt;
    logic [31:0]                           stall_out_cnt;
`endif

    modport slave (
        input  cfg_valid, cfg_func, cfg_rows, in_valid, in_data, act_out, out_ready,
        output cfg_ready, in_ready, act_in, act_sel, out_valid, out_data, out_last, busy, done
`ifdef ACT_CTRL_PERF_EN
        , output stall_in_cnt, stall_out_cnt
`endif
    );

    modport master (
        output cfg_valid, cfg_func, cfg_rows, in_valid, in_data, act_out, out_ready,
        input  cfg_ready, in_ready, act_in, act_sel, out_valid, out_data, out_last, busy, done
`ifdef ACT_CTRL_PERF_EN
        , input stall_in_cnt, stall_out_cnt
`endif
    );

endinterface

// File: rtl/activation_controller_out_fifo.sv
// rtl/activation_controller_out_fifo.sv - 2-entry row buffer behind the activation unit
// Module act_out_fifo. Ports: clk, rst (sync active-high), push/push_data/push_tag (write),
// pop (read), occ (0..2), head_data/head_tag (oldest entry; tag is the row index within the layer).
// The caller never pushes when full and never pops when empty.
module act_out_fifo
    import act_pkg::*;
#(
    parameter int ROW_BITS = ACT_DATA_WIDTH * ACT_SA_LENGTH,
    parameter int TAG_W    = ACT_ROW_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [ROW_BITS-1:0] push_data,
    input  logic [TAG_W-1:0]    push_tag,
    input  logic                pop,
    output logic [1:0]          occ,
    output logic [ROW_BITS-1:0] head_data,
    output logic [TAG_W-1:0]    head_tag
);

    logic [ROW_BITS-1:0] data_mem [OUT_DEPTH];
    logic [TAG_W-1:0]    tag_mem  [OUT_DEPTH];

    // Depth is two, so each pointer is a single toggling bit.
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= push_data;
            tag_mem[wr_ptr_q]  <= push_tag;
        end
    end

    assign occ       = occ_q;
    assign head_data = data_mem[rd_ptr_q];
    assign head_tag  = tag_mem[rd_ptr_q];

endmodule

// File: rtl/activation_controller.sv
// rtl/activation_controller.sv - per-layer sequencer between accumulator output and writeback
// Ports: clk, rst (sync active-high), bus (activation_controller_if.slave: cfg_*, in_*, act_*, out_*, busy, done).
// Optional macro ACT_CTRL_PERF_EN adds bus.stall_in_cnt / bus.stall_out_cnt saturating stall counters.
// The activation unit has a fixed 1-cycle latency and cannot stall, so rows are only issued when the
// 2-entry output buffer is guaranteed room for the result (credit-based issue).
module activation_controller
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int SA_LENGTH  = ACT_SA_LENGTH,
    parameter int ROW_W      = ACT_ROW_W
) (
    input  logic                   clk,
    input  logic                   rst,
    activation_controller_if.slave bus
);

    localparam int               ROW_BITS = DATA_WIDTH * SA_LENGTH;
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    act_state_e          state_q, state_d;
    act_func_e           func_q;
    logic [ROW_W-1:0]    rows_q;
    logic [ROW_W-1:0]    issued_q;
    logic [ROW_W-1:0]    retired_q;
    logic                inflight_q;
    logic [ROW_W-1:0]    inflight_idx_q;

    logic [1:0]          occ;
    logic [ROW_BITS-1:0] head_data;
    logic [ROW_W-1:0]    head_tag;

    logic                cfg_ready;
    logic                cfg_fire;
    logic                in_ready;
    logic                in_fire;
    logic                out_valid;
    logic                out_fire;
    logic                busy;
    logic                done;

    assign out_valid = (occ != 2'd0);
    assign out_fire  = out_valid && bus.out_ready;
    assign cfg_fire  = bus.cfg_valid && cfg_ready;
    assign in_fire   = bus.in_valid && in_ready;

    // Credit check: rows already owning a buffer slot (buffered + in flight), less the one leaving
    // this cycle, must be below the depth. Written as a sum compare to avoid underflow.
    assign in_ready = (state_q == RUN) && (issued_q < rows_q) &&
                      (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, out_fire}));

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (bus.cfg_valid) begin
                    state_d = (bus.cfg_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issued_q == rows_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_fire && (retired_q == rows_q - ROW_ONE)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            func_q         <= BYPASS;
            rows_q         <= '0;
            issued_q       <= '0;
            retired_q      <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= in_fire;
            if (in_fire) begin
                issued_q       <= issued_q + ROW_ONE;
                inflight_idx_q <= issued_q;
            end
            if (out_fire) retired_q <= retired_q + ROW_ONE;
            // Function only changes on config accept, i.e. in IDLE, so no row sees a select change.
            if (cfg_fire) begin
                func_q    <= act_func_e'(bus.cfg_func);
                rows_q    <= bus.cfg_rows;
                issued_q  <= '0;
                retired_q <= '0;
            end
        end
    end

    // The in-flight row's activation result is valid on act_out this cycle; capture it.
    act_out_fifo #(
        .ROW_BITS (ROW_BITS),
        .TAG_W    (ROW_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.act_out),
        .push_tag  (inflight_idx_q),
        .pop       (out_fire),
        .occ       (occ),
        .head_data (head_data),
        .head_tag  (head_tag)
    );

    assign bus.cfg_ready = cfg_ready;
    assign bus.in_ready  = in_ready;
    assign bus.act_in    = bus.in_data;
    assign bus.act_sel   = func_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_data;
    assign bus.out_last  = out_valid && (head_tag == rows_q - ROW_ONE);
    assign bus.busy      = busy;
    assign bus.done      = done;

`ifdef ACT_CTRL_PERF_EN
    logic [31:0] stall_in_q;
    logic [31:0] stall_out_q;

    always_ff @(posedge clk) begin
        if (rst || cfg_fire) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            if ((state_q == RUN) && bus.in_valid && !in_ready && (stall_in_q != '1)) begin
                stall_in_q <= stall_in_q + 32'd1;
            end
            if (out_valid && !bus.out_ready && (stall_out_q != '1)) begin
                stall_out_q <= stall_out_q + 32'd1;
            end
        end
    end

    assign bus.stall_in_cnt  = stall_in_q;
    assign bus.stall_out_cnt = stall_out_q;
`endif

endmodule

// File: tb/tb_activation_controller.sv
// tb/tb_activation_controller.sv - directed scoreboard bench for activation_controller
module tb_activation_controller;
    import act_pkg::*;

    localparam int DW = ACT_DATA_WIDTH;
    localparam int SA = ACT_SA_LENGTH;
    localparam int RW = ACT_ROW_W;
    localparam int RB = DW * SA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    activation_controller_if #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .ROW_W(RW)) bus ();

    activation_controller #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .ROW_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in activation unit: one registered stage, distinct transform per select.
    function automatic logic [RB-1:0] act_fn(input logic [RB-1:0] x, input logic [1:0] f);
        logic [RB-1:0]         r;
        logic signed [DW-1:0]  v;
        r = '0;
        for (int i = 0; i < SA; i++) begin
            v = x[i*DW +: DW];
            case (f)
                2'd0:    r[i*DW +: DW] = (v < 0) ? '0 : v;
                2'd1:    r[i*DW +: DW] = v ^ DW'('h2aa);
                2'd2:    r[i*DW +: DW] = -v;
                default: r[i*DW +: DW] = v;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk) bus.act_out <= act_fn(bus.act_in, bus.act_sel);

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    logic [RB-1:0] sb_data[$];
    logic          sb_last[$];
    logic [1:0]    exp_func;
    logic [RW-1:0] exp_rows;
    int            tb_issued;
    int            in_fires[$];
    int            out_fires[$];
    int            done_cycs[$];
    int            cfg_accepts;
    int            cfg_cyc;
    int            sel_bad;
    logic          last_in_fire;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
        int lane;
        lane = 0;
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            for (int i = SA - 1; i >= 0; i--) if (obs[i*DW +: DW] !== exp[i*DW +: DW]) lane = i;
            $error("FAIL %s: lane %0d got %0h expected %0h", tag, lane, obs[lane*DW +: DW], exp[lane*DW +: DW]);
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < SA; i++) bus.in_data[i] = DW'($urandom);
    endtask

    // Sample at the falling edge, update the scoreboard, then return just after the next rising edge.
    task automatic cycle();
        logic [RB-1:0] ed;
        logic          el;
        @(negedge clk);
        cyc++;
        last_in_fire = 1'b0;
        if (bus.busy && (bus.act_sel !== exp_func)) sel_bad++;
        if (bus.done) done_cycs.push_back(cyc);
        if (!rst && bus.cfg_valid && bus.cfg_ready) begin
            exp_func = bus.cfg_func;
            exp_rows = bus.cfg_rows;
            tb_issued = 0;
            cfg_accepts++;
            cfg_cyc = cyc;
        end
        if (!rst && bus.in_valid && bus.in_ready) begin
            sb_data.push_back(act_fn(bus.in_data, exp_func));
            sb_last.push_back(tb_issued == int'(exp_rows) - 1);
            tb_issued++;
            in_fires.push_back(cyc);
            last_in_fire = 1'b1;
        end
        if (!rst && bus.out_valid && bus.out_ready) begin
            out_fires.push_back(cyc);
            chk("out_has_expected_row", sb_data.size() != 0, 1'b1);
            if (sb_data.size() != 0) begin
                ed = sb_data.pop_front();
                el = sb_last.pop_front();
                chk_row("out_data", bus.out_data, ed);
                chk("out_last", bus.out_last, el);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic refresh_in();
        if (!bus.in_valid || last_in_fire) new_data();
    endtask

    task automatic clear_logs();
        in_fires.delete();
        out_fires.delete();
        done_cycs.delete();
        sel_bad = 0;
    endtask

    task automatic send_cfg(input logic [1:0] f, input logic [RW-1:0] r);
        bus.cfg_valid = 1'b1;
        bus.cfg_func  = f;
        bus.cfg_rows  = r;
        cycle();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_func = 2'd0; bus.cfg_rows = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        exp_func = 2'd3; exp_rows = '0; tb_issued = 0; cfg_accepts = 0; cfg_cyc = 0;
        sel_bad = 0; last_in_fire = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_act_sel", bus.act_sel, 2'b11);
        @(posedge clk);
        #1;

        // Streaming, ReLU, 4 rows at full throughput
        clear_logs();
        send_cfg(2'd0, RW'(4));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && done_cycs.size() == 0; i++) begin
            refresh_in();
            chk_row("act_in_passthru", bus.act_in, bus.in_data);
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (2) cycle();
        chk("t1_done_pulses", done_cycs.size(), 1);
        chk("t1_in_fires", in_fires.size(), 4);
        chk("t1_out_fires", out_fires.size(), 4);
        if (in_fires.size() == 4 && out_fires.size() == 4 && done_cycs.size() == 1) begin
            chk("t1_in_consecutive", in_fires[3] - in_fires[0], 3);
            chk("t1_first_latency", out_fires[0] - in_fires[0], 2);
            chk("t1_out_consecutive", out_fires[3] - out_fires[0], 3);
            chk("t1_done_after_last", done_cycs[0] - out_fires[3], 1);
        end
        chk("t1_sel_stable", sel_bad, 0);
        chk("t1_idle", bus.busy, 1'b0);

        // Backpressure, sigmoid, 5 rows with out_ready low for 10 cycles
        clear_logs();
        send_cfg(2'd1, RW'(5));
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        repeat (10) begin refresh_in(); cycle(); end
        chk("t2_held_rows", in_fires.size(), 2);
        chk("t2_in_ready_low", bus.in_ready, 1'b0);
        chk("t2_no_out", out_fires.size(), 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && done_cycs.size() == 0; i++) begin refresh_in(); cycle(); end
        bus.in_valid = 1'b0;
        cycle();
        chk("t2_done_pulses", done_cycs.size(), 1);
        chk("t2_out_fires", out_fires.size(), 5);
        chk("t2_sb_empty", sb_data.size(), 0);

        // Zero-row layer
        clear_logs();
        bus.in_valid = 1'b1;
        send_cfg(2'd2, RW'(0));
        for (int i = 0; i < 6 && done_cycs.size() == 0; i++) cycle();
        repeat (2) cycle();
        bus.in_valid = 1'b0;
        chk("t3_done_pulses", done_cycs.size(), 1);
        chk("t3_no_in_fire", in_fires.size(), 0);
        if (done_cycs.size() == 1) chk("t3_done_timing", done_cycs[0] - cfg_cyc, 1);
        chk("t3_idle", bus.busy, 1'b0);

        // Select stability: config offered during RUN waits for IDLE
        clear_logs();
        base = cfg_accepts;
        send_cfg(2'd2, RW'(6));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (2) begin refresh_in(); cycle(); end
        bus.cfg_valid = 1'b1; bus.cfg_func = 2'd1; bus.cfg_rows = RW'(3);
        chk("t4_cfg_ready_run", bus.cfg_ready, 1'b0);
        chk("t4_act_sel_run", bus.act_sel, 2'd2);
        for (int i = 0; i < 80 && done_cycs.size() < 2; i++) begin
            refresh_in();
            cycle();
            if (cfg_accepts == base + 2) bus.cfg_valid = 1'b0;
        end
        bus.cfg_valid = 1'b0; bus.in_valid = 1'b0;
        cycle();
        chk("t4_accepts", cfg_accepts - base, 2);
        chk("t4_done_pulses", done_cycs.size(), 2);
        chk("t4_out_fires", out_fires.size(), 9);
        chk("t4_sel_stable", sel_bad, 0);
        chk("t4_act_sel_new", bus.act_sel, 2'd1);

        // Reset mid-layer with one row buffered and one in flight
        clear_logs();
        send_cfg(2'd0, RW'(6));
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        for (int i = 0; i < 10 && tb_issued < 2; i++) begin refresh_in(); cycle(); end
        chk("t5_issued_before_rst", in_fires.size(), 2);
        rst = 1'b1; bus.in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        sb_data.delete(); sb_last.delete();
        @(negedge clk);
        chk("t5_out_valid", bus.out_valid, 1'b0);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_act_sel", bus.act_sel, 2'b11);
        chk("t5_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        repeat (3) cycle();
        chk("t5_no_done", done_cycs.size(), 0);

        // Bypass with random stalls on both sides
        clear_logs();
        send_cfg(2'd3, RW'(8));
        for (int i = 0; i < 400 && done_cycs.size() == 0; i++) begin
            if (!bus.in_valid || last_in_fire) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                new_data();
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("t6_done_pulses", done_cycs.size(), 1);
        chk("t6_in_fires", in_fires.size(), 8);
        chk("t6_out_fires", out_fires.size(), 8);
        chk("t6_sb_empty", sb_data.size(), 0);
        chk("t6_sel_stable", sel_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/activation_controller.md
Name: activation_controller

Overview:
- Sequences the per-layer activation stage between the systolic-array accumulator output and the writeback path.
- Latches a per-layer config (function, row count) and streams SA_LENGTH-lane rows through the activation unit over valid/ready handshakes.
- The activation unit has a fixed 1-cycle registered latency and cannot stall. The controller therefore uses credit-based issue and a 2-entry output buffer to sustain 1 row/cycle under downstream backpressure.

Parameters:
- DATA_WIDTH, 11, lane width (signed fixed point).
- SA_LENGTH, 256, lanes per row.
- ROW_W, 16, width of the row counter; max rows per layer is 2^ROW_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  layer config offered.
- cfg_ready  out  1  config accepted when high; high only in IDLE.
- cfg_func  in  2  0=ReLU, 1=sigmoid, 2=tanh, 3=bypass.
- cfg_rows  in  ROW_W  rows in this layer.
- in_valid  in  1  accumulator row valid.
- in_ready  out  1  row accepted.
- in_data  in  SA_LENGTH x DATA_WIDTH signed  accumulator row.
- act_in  out  SA_LENGTH x DATA_WIDTH signed  to activation unit input.
- act_sel  out  2  to activation unit select.
- act_out  in  SA_LENGTH x DATA_WIDTH signed  activation unit registered output.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts.
- out_data  out  SA_LENGTH x DATA_WIDTH signed  result row.
- out_last  out  1  marks the final row of the layer.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle pulse when the last row is accepted downstream.

Behaviour:
- Reset values: state=IDLE, act_sel=2'b11, buffer empty, out_valid=0, in_ready=0, out_last=0, done=0, all counters 0, inflight=0.
- FSM states:
  - IDLE: cfg_ready=1. On cfg_valid, latch func and rows. If rows==0, go to DONE (no data phase). Otherwise go to RUN with issued=0 and retired=0.
  - RUN: issue rows. Go to DRAIN when issued==rows.
  - DRAIN: wait for in-flight and buffered rows to drain. Go to DONE on the cycle the last row fires at the output.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- act_sel is driven from the latched func in every non-IDLE state. It changes only in IDLE, so it never changes while a row is in flight.
- act_in = in_data, combinational pass-through.
- Issue rule: in_ready = (state==RUN) && (issued<rows) && (occ + inflight - out_fire < 2).
  - occ is buffer occupancy (0..2); out_fire = out_valid && out_ready.
  - in_fire = in_valid && in_ready. On in_fire, issued increments and inflight is set to 1 for the next cycle.
- Capture: when inflight==1, act_out is written into the buffer at the end of that cycle.
  - Latency from in_fire in cycle t to out_valid is 2 cycles (out_valid in t+2 when the buffer was empty).
- Buffer is a 2-entry FIFO.
  - out_valid = occ>0; out_data = head entry.
  - A simultaneous write and read at occ==2 is impossible by the issue rule. At occ==1 occupancy stays 1.
- out_last=1 when the head row's index == rows-1. retired increments on out_fire.
- Full throughput: with out_ready held high, one row is issued per cycle.
- Backpressure: with out_ready low, at most 2 rows are held (buffer plus in-flight). in_ready drops in the same cycle the limit is reached, so no row is ever lost.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- Reset mid-operation: the buffer and in-flight row are discarded, the FSM returns to IDLE, and no done pulse is produced.

Optional Feature:
- Macro ACT_CTRL_PERF_EN. When defined, adds two outputs, stall_in_cnt and stall_out_cnt, each 32 bits.
  - stall_in_cnt counts RUN cycles with in_valid && !in_ready.
  - stall_out_cnt counts cycles with out_valid && !out_ready.
  - Both clear on cfg accept and on rst, and saturate at all-ones.
- When undefined, neither port nor logic exists. Functional behaviour is identical either way.

Decomposition:
- Package act_pkg:
  - act_func_e enum: RELU=0, SIGMOID=1, TANH=2, BYPASS=3.
  - act_state_e enum: IDLE, RUN, DRAIN, DONE.
  - Row typedef: logic signed [DATA_WIDTH-1:0] [SA_LENGTH].
  - Constant OUT_DEPTH=2.
- Sub-module act_out_fifo: 2-entry row FIFO exposing push, pop, occ, head, and a head-index tag for out_last. The FSM, counters and issue logic stay in activation_controller.

Test Plan:
- Streaming: cfg func=0, rows=4, in_valid and out_ready held 1 -> in_fire on 4 consecutive cycles; out_valid 2 cycles after the first fire, 4 consecutive rows; out_last on row 3; done 1 cycle after the last out_fire; act_sel=0 throughout.
- Backpressure: rows=5, out_ready=0 for 10 cycles -> exactly 2 rows accepted, then in_ready=0; on release all 5 rows arrive in order with correct data.
- Zero rows: cfg rows=0 -> IDLE to DONE, done pulses, in_ready never asserts.
- Select stability: cfg func=2, then cfg_valid with func=1 asserted during RUN -> ignored, act_sel stays 2 until IDLE; the next layer uses 1.
- Reset mid-layer: rst after 2 of 6 rows with 1 row in flight -> out_valid=0 and busy=0 next cycle, act_sel=3; a new layer then runs cleanly.
- Bypass with random stalls: func=3, rows=8, random in_valid/out_ready -> out_data equals the input rows bit-exactly, in order, with 8 out_fires.
